// File: rtl/axil_arb_pkg.sv
// Shared types for the AXI-Lite read/write round-robin arbiters.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  // Index width that stays at least one bit for a single master.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axil_rr_pick.sv
// Rotating-priority search: first requester after last_idx, with wrap.
module axil_rr_pick
  import axil_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] last_idx,
  output logic [N-1:0]     pick_oh,
  output logic [IDX_W-1:0] pick_idx
);

  int unsigned start;
  int unsigned win;
  logic        found;
  logic [N-1:0] rot;

  // Rotate so that bit 0 of rot is the highest-priority master.
  always_comb begin
    start = 32'(last_idx) + 32'd1;
    if (start >= N) start = start - N;
    rot   = N'({request, request} >> start);
    found = 1'b0;
    win   = 0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        win   = start + j;
        if (win >= N) win = win - N;
      end
    end
    pick_idx = IDX_W'(win);
    pick_oh  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pick_oh[k] = found && (k == win);
    end
  end

endmodule

// File: rtl/axil_arbiter_rr_wr.sv
// Round-robin write arbiter: one AXI-Lite write transaction (AW, W, B) per grant.
module axil_arbiter_rr_wr
  import axil_arb_pkg::*;
#(
  parameter int unsigned NUMBER_MASTER = 4,
  localparam int unsigned IDX_W = idx_width(NUMBER_MASTER)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUMBER_MASTER-1:0] request_wr,
  output logic [NUMBER_MASTER-1:0] grant_wr,
  output logic [IDX_W-1:0]         grant_wr_idx,
  input  logic                     s_axil_awvalid,
  input  logic                     s_axil_awready,
  input  logic                     s_axil_wvalid,
  input  logic                     s_axil_wready,
  input  logic                     s_axil_bvalid,
  input  logic [NUMBER_MASTER-1:0] m_axil_bready
);

  wr_state_e                state, state_d;
  logic [NUMBER_MASTER-1:0] grant_d;
  logic [IDX_W-1:0]         grant_idx_d;
  logic [IDX_W-1:0]         last_idx, last_idx_d;
  logic                     aw_done, aw_done_d;
  logic                     w_done, w_done_d;
  logic [NUMBER_MASTER-1:0] pick_oh;
  logic [IDX_W-1:0]         pick_idx;
  logic                     aw_hs, w_hs, b_hs, both_done;

  axil_rr_pick #(.N(NUMBER_MASTER)) u_pick (
    .request  (request_wr),
    .last_idx (last_idx),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

  // grant_wr is one-hot, so masking bready selects the granted master's ready.
  assign aw_hs     = s_axil_awvalid && s_axil_awready;
  assign w_hs      = s_axil_wvalid && s_axil_wready;
  assign b_hs      = s_axil_bvalid && (|(m_axil_bready & grant_wr));
  assign both_done = (aw_done || aw_hs) && (w_done || w_hs);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state        <= IDLE;
      grant_wr     <= '0;
      grant_wr_idx <= '0;
      last_idx     <= IDX_W'(NUMBER_MASTER - 1);
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
    end else begin
      state        <= state_d;
      grant_wr     <= grant_d;
      grant_wr_idx <= grant_idx_d;
      last_idx     <= last_idx_d;
      aw_done      <= aw_done_d;
      w_done       <= w_done_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (|request_wr) state_d = ADDR_DATA;
      ADDR_DATA: if (both_done)   state_d = RESP;
      RESP:      if (b_hs)        state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Next values for the registered grant, pointer and handshake flags.
  always_comb begin
    grant_d     = grant_wr;
    grant_idx_d = grant_wr_idx;
    last_idx_d  = last_idx;
    aw_done_d   = aw_done;
    w_done_d    = w_done;
    case (state)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (|request_wr) begin
          grant_d     = pick_oh;
          grant_idx_d = pick_idx;
          last_idx_d  = pick_idx;
        end else begin
          grant_d     = '0;
          grant_idx_d = '0;
        end
      end
      ADDR_DATA: begin
        if (both_done) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done || aw_hs;
          w_done_d  = w_done || w_hs;
        end
      end
      RESP: begin
        if (b_hs) begin
          grant_d     = '0;
          grant_idx_d = '0;
        end
      end
      default: begin
        grant_d     = '0;
        grant_idx_d = '0;
        aw_done_d   = 1'b0;
        w_done_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axil_arbiter_rr_wr.sv
// Directed bench for the round-robin AXI-Lite write arbiter (4 masters).
module tb_axil_arbiter_rr_wr;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [3:0] request_wr;
  logic [3:0] grant_wr;
  logic [1:0] grant_wr_idx;
  logic       s_axil_awvalid, s_axil_awready;
  logic       s_axil_wvalid, s_axil_wready;
  logic       s_axil_bvalid;
  logic [3:0] m_axil_bready;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axil_arbiter_rr_wr #(.NUMBER_MASTER(4)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .request_wr     (request_wr),
    .grant_wr       (grant_wr),
    .grant_wr_idx   (grant_wr_idx),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bvalid  (s_axil_bvalid),
    .m_axil_bready  (m_axil_bready)
  );

  task automatic drive(input logic [3:0] req, input logic aw, input logic w,
                       input logic b, input logic [3:0] bready);
    request_wr     = req;
    s_axil_awvalid = aw;
    s_axil_awready = aw;
    s_axil_wvalid  = w;
    s_axil_wready  = w;
    s_axil_bvalid  = b;
    m_axil_bready  = bready;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei);
    checks++;
    assert (grant_wr === eg) else begin
      failures++;
      $error("FAIL %s grant_wr observed=%b expected=%b", tag, grant_wr, eg);
    end
    checks++;
    assert (grant_wr_idx === ei) else begin
      failures++;
      $error("FAIL %s grant_wr_idx observed=%0d expected=%0d", tag, grant_wr_idx, ei);
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    aresetn = 1'b0;
    drive(4'b0000, 0, 0, 0, 4'b0000);
    step();
    step();
    chk("reset", 4'b0000, 2'd0);
    aresetn = 1'b1;

    // All masters requesting: rotate 0,1,2,3,0 with one idle cycle between grants
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      drive(4'b1111, 0, 0, 0, 4'b0000);
      step();
      chk("rr_grant", exp_g, 2'(k % 4));
      drive(4'b1111, 1, 0, 0, 4'b0000);
      step();
      chk("rr_after_aw", exp_g, 2'(k % 4));
      drive(4'b1111, 0, 1, 0, 4'b0000);
      step();
      chk("rr_after_w", exp_g, 2'(k % 4));
      drive(4'b1111, 0, 0, 1, 4'b1111);
      step();
      chk("rr_release", 4'b0000, 2'd0);
    end

    // W two cycles before AW; bvalid held early must not release before RESP
    drive(4'b0100, 0, 0, 0, 4'b0000);
    step();
    chk("w_first_grant", 4'b0100, 2'd2);
    drive(4'b0100, 0, 1, 1, 4'b0100);
    step();
    chk("w_first_w", 4'b0100, 2'd2);
    drive(4'b0100, 0, 0, 1, 4'b0100);
    step();
    chk("w_first_gap", 4'b0100, 2'd2);
    drive(4'b0100, 1, 0, 1, 4'b0100);
    step();
    chk("w_first_aw", 4'b0100, 2'd2);
    drive(4'b0000, 0, 0, 1, 4'b0100);
    step();
    chk("w_first_release", 4'b0000, 2'd0);

    // Same-cycle AW/W, then bready for another master only
    drive(4'b0100, 0, 0, 0, 4'b0000);
    step();
    chk("same_cycle_grant", 4'b0100, 2'd2);
    drive(4'b0000, 1, 1, 1, 4'b1011);
    step();
    chk("same_cycle_resp", 4'b0100, 2'd2);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bready_low_hold", 4'b0100, 2'd2);
    end
    drive(4'b0000, 0, 0, 1, 4'b0100);
    step();
    chk("bready_release", 4'b0000, 2'd0);

    // Master 1 drops its request mid-transaction; stale flags would end it early
    drive(4'b0010, 0, 0, 0, 4'b0000);
    step();
    chk("drop_grant", 4'b0010, 2'd1);
    drive(4'b0000, 0, 0, 1, 4'b0010);
    step();
    chk("drop_hold_a", 4'b0010, 2'd1);
    step();
    chk("drop_hold_b", 4'b0010, 2'd1);
    drive(4'b0000, 1, 1, 1, 4'b0010);
    step();
    chk("drop_resp", 4'b0010, 2'd1);
    step();
    chk("drop_release", 4'b0000, 2'd0);
    drive(4'b0000, 0, 0, 0, 4'b0000);
    step();
    chk("drop_idle", 4'b0000, 2'd0);

    // Reset in RESP with master 3 granted
    drive(4'b1000, 0, 0, 0, 4'b0000);
    step();
    chk("rst_grant", 4'b1000, 2'd3);
    drive(4'b1000, 1, 1, 0, 4'b0000);
    step();
    chk("rst_resp", 4'b1000, 2'd3);
    drive(4'b1000, 0, 0, 0, 4'b0000);
    aresetn = 1'b0;
    step();
    chk("rst_abort", 4'b0000, 2'd0);
    aresetn = 1'b1;
    drive(4'b1010, 0, 0, 0, 4'b0000);
    step();
    chk("rst_regrant", 4'b0010, 2'd1);
    drive(4'b0000, 1, 1, 0, 4'b0000);
    step();
    chk("rst_regrant_resp", 4'b0010, 2'd1);
    drive(4'b0000, 0, 0, 1, 4'b0010);
    step();
    chk("rst_regrant_release", 4'b0000, 2'd0);

    // Stray handshakes while idle must not count toward the next transaction
    drive(4'b0000, 1, 1, 0, 4'b0000);
    step();
    chk("stray_idle", 4'b0000, 2'd0);
    drive(4'b0001, 1, 1, 0, 4'b0000);
    step();
    chk("stray_grant", 4'b0001, 2'd0);
    drive(4'b0000, 0, 0, 1, 4'b0001);
    step();
    chk("stray_hold_a", 4'b0001, 2'd0);
    step();
    chk("stray_hold_b", 4'b0001, 2'd0);
    drive(4'b0000, 1, 0, 1, 4'b0001);
    step();
    chk("stray_aw", 4'b0001, 2'd0);
    drive(4'b0000, 0, 1, 1, 4'b0001);
    step();
    chk("stray_w_resp", 4'b0001, 2'd0);
    step();
    chk("stray_release", 4'b0000, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_arbiter_rr_wr.md
AXIL_ARBITER_RR_WR -- requirements
Module: axil_arbiter_rr_wr

Interface
REQ-001 Parameter NUMBER_MASTER, default 4, SHALL set the number of AXI-Lite write masters sharing one slave port; legal range 1..32.
REQ-002 aclk  input  1  SHALL be the clock; all logic rising-edge.
REQ-003 aresetn  input  1  SHALL be the reset, synchronous, active-low.
REQ-004 request_wr  input  NUMBER_MASTER  SHALL be the per-master write request (awvalid-derived).
REQ-005 grant_wr  output  NUMBER_MASTER  SHALL be the registered one-hot write grant.
REQ-006 grant_wr_idx  output  $clog2(max(NUMBER_MASTER,2))  SHALL be the binary index of grant_wr; 0 when no grant.
REQ-007 s_axil_awvalid, s_axil_awready  input  1 each  SHALL be the muxed AW handshake at the slave port.
REQ-008 s_axil_wvalid, s_axil_wready  input  1 each  SHALL be the muxed W handshake at the slave port.
REQ-009 s_axil_bvalid  input  1  SHALL be the slave write-response valid.
REQ-010 m_axil_bready  input  NUMBER_MASTER  SHALL be the per-master B-channel ready.

Function
REQ-011 FSM SHALL have states IDLE, ADDR_DATA, RESP.
REQ-012 IDLE: if request_wr is nonzero, next cycle SHALL load grant_wr/grant_wr_idx with the round-robin winner and enter ADDR_DATA; otherwise remain IDLE with grant_wr = 0.
REQ-013 Round-robin winner SHALL be the first requesting index scanning from (last_idx+1) mod NUMBER_MASTER upward with wrap; last_idx resets to NUMBER_MASTER-1 so master 0 wins first.
REQ-014 last_idx SHALL update to the winner index on the cycle the grant is loaded.
REQ-015 ADDR_DATA: aw_done SHALL set on s_axil_awvalid&&s_axil_awready, w_done on s_axil_wvalid&&s_axil_wready; either order or the same cycle is legal.
REQ-016 FSM SHALL enter RESP on the cycle both handshakes are complete (flag set or handshake in that cycle); flags clear on entering RESP.
REQ-017 RESP: on s_axil_bvalid && m_axil_bready[grant_wr_idx], next cycle SHALL clear grant_wr, grant_wr_idx to 0 and return to IDLE.
REQ-018 Grant SHALL be held from load until the B handshake regardless of request_wr deassertion or other requests.
REQ-019 Back-to-back: after a B handshake one IDLE cycle SHALL occur before the next grant (request-to-grant latency one cycle).
REQ-020 AW/W handshakes in RESP or IDLE SHALL be ignored (no flag change).
REQ-021 grant_wr SHALL be one-hot or zero at all times.
REQ-022 NUMBER_MASTER=1 SHALL degenerate to a single-master sequencer with grant_wr_idx fixed 0.

Reset
REQ-023 Under aresetn=0: state IDLE, grant_wr=0, grant_wr_idx=0, aw_done=w_done=0, last_idx=NUMBER_MASTER-1.
REQ-024 Reset mid-transaction SHALL abort immediately; the next grant after reset SHALL follow REQ-013 from the reset pointer.

Structure
REQ-025 State enum (IDLE, ADDR_DATA, RESP) SHALL live in shared package axil_arb_pkg alongside the read-arbiter types.
REQ-026 The rotating priority search SHALL be sub-module axil_rr_pick (inputs request, last_idx; outputs one-hot and index), purely combinational.
REQ-027 Outputs SHALL be driven from registers only; no combinational path from inputs to grant_wr.

Verification
REQ-028 N=4, request_wr=4'b1111 held, each transaction AW, W, B one cycle apart -> grants 0001, 0010, 0100, 1000, 0001 in order.
REQ-029 request_wr=4'b0100 only, W handshake two cycles before AW -> RESP entered cycle after AW handshake; grant 0100 held until bvalid&&bready[2].
REQ-030 AW and W handshake same cycle -> RESP next cycle; bvalid high with m_axil_bready[2]=0 for 3 cycles -> grant held; released cycle after bready[2]=1.
REQ-031 Grant on master 1, then request_wr drops to 0 mid-ADDR_DATA -> grant_wr stays 0010 through B handshake, then IDLE.
REQ-032 aresetn asserted during RESP with grant 1000 -> next cycle grant_wr=0, idx=0; request_wr=1010 after reset -> grant 0010.
REQ-033 Stray AW/W handshakes in IDLE then request -> FSM waits for fresh AW and W before RESP.
